// File: rtl/sprite_pkg.sv
// Shared sprite types and constants for the line-preparation scanner and the
// line renderer.
package sprite_pkg;

  localparam int SPR_SIZE   = 16;   // sprite width/height in pixels
  localparam int LINE_WIDTH = 640;  // visible pixels per line

  // One OAM word as seen on oam_data.
  typedef struct packed {
    logic       en;
    logic       yflip;
    logic       xflip;
    logic       prio;
    logic [9:0] y;
    logic [9:0] x;
    logic [7:0] spr_ref;
  } oam_entry_t;

  // One selection-buffer entry: bit 0 is the enable flag.
  typedef struct packed {
    logic [7:0] idx;
    logic       en;
  } buf_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    OAM_WAIT,
    SPR_WAIT,
    DRAW,
    DONE
  } state_e;

endpackage

// File: rtl/sprite_line_renderer_row_shifter.sv
// Holds one fetched 16-pixel sprite row and selects the 4-bit pixel for the
// current draw column, mirrored when the sprite is horizontally flipped.
module sprite_row_shifter
  import sprite_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [SPR_SIZE*4-1:0]   row_in,
  input  logic                    xflip,
  input  logic [3:0]              col,
  output logic [3:0]              pix
);

  logic [SPR_SIZE*4-1:0] row_q, row_d;
  logic [3:0]            sel;

  // Capture a new row only when the renderer asks for it.
  always_comb begin
    row_d = load ? row_in : row_q;
  end

  // Row register; it is cleared on reset so scan-out never sees stale X pixels.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    if (!reset_n) row_q <= '0;
    else          row_q <= row_d;
  end

  // Mirrored column is 15-col, which for a 4-bit index is a bitwise invert.
  assign sel = col ^ {4{xflip}};
  assign pix = row_q[{sel, 2'b00} +: 4];

endmodule

// File: rtl/sprite_line_renderer.sv
// Walks the per-line sprite selection buffer from the last entry down to entry 0,
// fetches each sprite's OAM word and row, and writes its opaque pixels into the
// scan-out line buffer. Entry 0 is drawn last so it wins overlaps.
module sprite_line_renderer #(
  parameter int MAX_OBJECT = 4,
  parameter int LINE_WIDTH = sprite_pkg::LINE_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    line_prepared,
  input  logic [9*MAX_OBJECT-1:0] buf_entries,
  input  logic [9:0]              sy,
  output logic [5:0]              oam_addr,
  input  logic [31:0]             oam_data,
  output logic [11:0]             sprite_addr,
  input  logic [63:0]             sprite_data,
  output logic                    lb_we,
  output logic [9:0]              lb_addr,
  output logic [4:0]              lb_data,
  output logic                    busy,
  output logic                    line_done
);
  import sprite_pkg::*;

  localparam int               IDX_W     = (MAX_OBJECT > 1) ? $clog2(MAX_OBJECT) : 1;
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(MAX_OBJECT - 1);
  localparam logic [3:0]       COL_LAST  = 4'(SPR_SIZE - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       col_q, col_d;
  logic [9:0]       x_q, x_d;
  logic             xflip_q, xflip_d;
  logic             prio_q, prio_d;

  buf_entry_t       cur_entry;
  oam_entry_t       oam;
  logic [9:0]       dy;
  logic [3:0]       row;
  logic [3:0]       pix;
  logic [10:0]      px_x;
  logic             row_load;
  state_e           adv_state;
  logic [IDX_W-1:0] adv_idx;
  logic             unused_bits;

  assign cur_entry = buf_entries[int'(idx_q) * 9 +: 9];
  assign oam       = oam_data;
  assign oam_addr  = cur_entry.idx[5:0];

  // Sprite row inside the sprite; the selection buffer already guaranteed 0..15.
  assign dy  = sy - oam.y;
  assign row = dy[3:0] ^ {4{oam.yflip}};

  // 11-bit screen x so sprites hanging off the right edge clip instead of wrapping.
  assign px_x = {1'b0, x_q} + 11'(col_q);

  // Only six OAM-index bits address OAM, and only the low row bits matter.
  assign unused_bits = ^{cur_entry.idx[7:6], dy[9:4]};

  // Where the walk goes after finishing (or skipping) the current entry.
  assign adv_state = (idx_q == '0) ? DONE : SELECT;
  assign adv_idx   = (idx_q == '0) ? idx_q : idx_q - 1'b1;

  sprite_row_shifter u_row (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (row_load),
    .row_in  (sprite_data),
    .xflip   (xflip_q),
    .col     (col_q),
    .pix     (pix)
  );

  // Next-state logic for the entry walk, including abort on line_prepared falling.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    col_d    = col_q;
    x_d      = x_q;
    xflip_d  = xflip_q;
    prio_d   = prio_q;
    row_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (line_prepared) begin
          state_d = SELECT;
          idx_d   = IDX_FIRST;
        end
      end
      SELECT: begin
        if (cur_entry.en) state_d = OAM_WAIT;
        else begin
          state_d = adv_state;
          idx_d   = adv_idx;
        end
      end
      OAM_WAIT: begin
        x_d     = oam.x;
        xflip_d = oam.xflip;
        prio_d  = oam.prio;
        if (oam.en) state_d = SPR_WAIT;
        else begin
          state_d = adv_state;
          idx_d   = adv_idx;
        end
      end
      SPR_WAIT: begin
        row_load = 1'b1;
        col_d    = '0;
        state_d  = DRAW;
      end
      DRAW: begin
        col_d = col_q + 4'd1;
        if (col_q == COL_LAST) begin
          state_d = adv_state;
          idx_d   = adv_idx;
        end
      end
      DONE: begin
        if (!line_prepared) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (busy && !line_prepared) state_d = IDLE;
  end

  // State and per-sprite attribute registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= IDX_FIRST;
      col_q   <= '0;
      x_q     <= '0;
      xflip_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      col_q   <= col_d;
      x_q     <= x_d;
      xflip_q <= xflip_d;
      prio_q  <= prio_d;
    end
  end

  // Outputs decoded from state; the line-buffer strobe also drops as soon as the line is withdrawn.
  always_comb begin
    busy        = 1'b0;
    line_done   = 1'b0;
    sprite_addr = '0;
    lb_we       = 1'b0;
    lb_addr     = '0;
    lb_data     = '0;
    case (state_q)
      SELECT, SPR_WAIT: busy = 1'b1;
      OAM_WAIT: begin
        busy        = 1'b1;
        sprite_addr = {oam.spr_ref, row};
      end
      DRAW: begin
        busy    = 1'b1;
        lb_addr = px_x[9:0];
        lb_data = {prio_q, pix};
        lb_we   = (pix != 4'd0) && (px_x < 11'(LINE_WIDTH)) && line_prepared;
      end
      DONE:    line_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Self-checking bench for sprite_line_renderer: directed scenarios plus random
// lines compared against a pixel-level reference model of the line.
`timescale 1ns/1ps
module tb_sprite_line_renderer;

  localparam int MAX_OBJECT = 4;
  localparam int LW         = 640;

  typedef logic [14:0] rec_t;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    line_prepared = 1'b0;
  logic [9*MAX_OBJECT-1:0] buf_entries = '0;
  logic [9:0]              sy = '0;
  logic [5:0]              oam_addr;
  logic [31:0]             oam_data = '0;
  logic [11:0]             sprite_addr;
  logic [63:0]             sprite_data = '0;
  logic                    lb_we;
  logic [9:0]              lb_addr;
  logic [4:0]              lb_data;
  logic                    busy;
  logic                    line_done;

  int checks = 0;
  int errors = 0;

  logic [31:0] oam_mem [64];
  logic [63:0] spr_rom [4096];
  logic [4:0]  linebuf [1024];
  rec_t        obs_w[$], exp_w[$], obs_sa[$], exp_sa[$];
  int          obs_cycles, exp_cycles;
  bit          done_seen;

  always #5 clk = ~clk;

  sprite_line_renderer #(.MAX_OBJECT(MAX_OBJECT), .LINE_WIDTH(LW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .line_prepared (line_prepared),
    .buf_entries   (buf_entries),
    .sy            (sy),
    .oam_addr      (oam_addr),
    .oam_data      (oam_data),
    .sprite_addr   (sprite_addr),
    .sprite_data   (sprite_data),
    .lb_we         (lb_we),
    .lb_addr       (lb_addr),
    .lb_data       (lb_data),
    .busy          (busy),
    .line_done     (line_done)
  );

  // Synchronous OAM and sprite memories: data valid one cycle after the address.
  always @(posedge clk) begin
    oam_data    <= oam_mem[oam_addr];
    sprite_data <= spr_rom[sprite_addr];
  end

  function automatic logic [31:0] mk_oam(logic en, logic yf, logic xf, logic pr,
                                         logic [9:0] y, logic [9:0] x, logic [7:0] r);
    return {en, yf, xf, pr, y, x, r};
  endfunction

  function automatic void set_entry(int i, logic en, logic [7:0] idx);
    buf_entries[i*9 +: 9] = {idx, en};
  endfunction

  // Reference: the list of line-buffer writes in order, the sprite rows fetched,
  // and the busy-cycle cost (skip 1, OAM-disabled 2, drawn 19).
  function automatic int model_line();
    int          cyc = 0;
    int          xx;
    logic [8:0]  e;
    logic [31:0] w;
    logic [3:0]  row, p;
    logic [11:0] sa;
    logic [63:0] px;
    exp_w.delete();
    exp_sa.delete();
    for (int i = MAX_OBJECT - 1; i >= 0; i--) begin
      e = buf_entries[i*9 +: 9];
      if (!e[0]) begin cyc += 1; continue; end
      w   = oam_mem[e[6:1]];
      row = 4'((int'(sy) - int'(w[27:18])) & 15);
      if (w[30]) row = 4'(15 - int'(row));
      sa = {w[7:0], row};
      if (sa != 0) exp_sa.push_back(rec_t'(sa));
      if (!w[31]) begin cyc += 2; continue; end
      cyc += 19;
      px = spr_rom[sa];
      for (int c = 0; c < 16; c++) begin
        p  = w[29] ? px[(15-c)*4 +: 4] : px[c*4 +: 4];
        xx = int'(w[17:8]) + c;
        if (p != 0 && xx < LW) exp_w.push_back({10'(xx), w[28], p});
      end
    end
    return cyc;
  endfunction

  function automatic int first_diff(input rec_t a[$], input rec_t b[$]);
    if (a.size() != b.size()) return -2;
    foreach (a[i]) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  // Raise line_prepared and record everything until line_done (bounded).
  task automatic run_line();
    obs_w.delete();
    obs_sa.delete();
    obs_cycles = 0;
    done_seen  = 0;
    @(posedge clk); #1 line_prepared = 1'b1;
    for (int k = 0; k < 400 && !done_seen; k++) begin
      @(negedge clk);
      if (lb_we) begin
        obs_w.push_back({lb_addr, lb_data});
        linebuf[lb_addr] = lb_data;
      end
      if (sprite_addr != 0) obs_sa.push_back(rec_t'(sprite_addr));
      if (busy) obs_cycles++;
      if (line_done) done_seen = 1;
    end
  endtask

  task automatic end_line();
    @(posedge clk); #1 line_prepared = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (lb_we !== 1'b0 || busy !== 1'b0 || line_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: we/busy/done=%b%b%b want 000", lb_we, busy, line_done);
    end
    checks++;
    if (sprite_addr !== 12'h0 || lb_addr !== 10'h0 || lb_data !== 5'h0) begin
      errors++;
      $display("FAIL reset_buses: saddr=%h lb_addr=%h lb_data=%h want 0", sprite_addr, lb_addr, lb_data);
    end
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || line_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b want 0 0", busy, line_done);
    end
  endtask

  task automatic test_single();
    int d;
    buf_entries = '0;
    set_entry(0, 1'b1, 8'd3);
    oam_mem[3]     = mk_oam(1, 0, 0, 0, 10'd50, 10'd100, 8'd7);
    spr_rom[12'h073] = {16{4'h5}};
    sy = 10'd53;
    exp_cycles = model_line();
    run_line();
    checks++;
    if (!done_seen || obs_cycles != 22) begin
      errors++;
      $display("FAIL single_cycles: done=%0d cycles=%0d want done=1 cycles=22", done_seen, obs_cycles);
    end
    checks++;
    if (obs_sa.size() != 1 || obs_sa[0] !== 15'h073) begin
      errors++;
      $display("FAIL single_saddr: got %0d fetches first=%h want 1 fetch 073", obs_sa.size(),
               obs_sa.size() ? obs_sa[0] : 15'h0);
    end
    d = first_diff(obs_w, exp_w);
    checks++;
    if (d != -1 || obs_w.size() != 16) begin
      errors++;
      $display("FAIL single_writes: got %0d writes want 16 (first diff %0d)", obs_w.size(), d);
    end
    @(negedge clk);
    checks++;
    if (line_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_hold: done=%b busy=%b want 1 0", line_done, busy);
    end
    end_line();
    checks++;
    if (line_done !== 1'b0) begin
      errors++;
      $display("FAIL single_release: done=%b want 0", line_done);
    end
  endtask

  task automatic test_flip();
    int d;
    buf_entries = '0;
    set_entry(0, 1'b1, 8'd5);
    oam_mem[5]       = mk_oam(1, 1, 1, 1, 10'd200, 10'd200, 8'd9);
    spr_rom[12'h09F] = 64'hFEDC_BA98_7654_3210;
    sy = 10'd200;
    exp_cycles = model_line();
    run_line();
    checks++;
    if (obs_sa.size() != 1 || obs_sa[0] !== 15'h09F) begin
      errors++;
      $display("FAIL flip_saddr: got %0d fetches first=%h want 09F", obs_sa.size(),
               obs_sa.size() ? obs_sa[0] : 15'h0);
    end
    checks++;
    if (obs_w.size() != 15) begin
      errors++;
      $display("FAIL flip_count: got %0d writes want 15", obs_w.size());
    end else begin
      for (int c = 0; c < 15; c++) begin
        checks++;
        if (obs_w[c] !== {10'(200 + c), 1'b1, 4'(15 - c)}) begin
          errors++;
          $display("FAIL flip_px%0d: got %h want %h", c, obs_w[c], {10'(200 + c), 1'b1, 4'(15 - c)});
        end
      end
    end
    d = first_diff(obs_w, exp_w);
    checks++;
    if (d != -1 || obs_cycles != exp_cycles) begin
      errors++;
      $display("FAIL flip_model: diff=%0d cycles=%0d want -1 %0d", d, obs_cycles, exp_cycles);
    end
    end_line();
  endtask

  task automatic test_clip();
    int d;
    buf_entries = '0;
    set_entry(0, 1'b1, 8'd8);
    spr_rom[12'h110] = {16{4'hA}};
    sy = 10'd300;
    for (int t = 0; t < 2; t++) begin
      oam_mem[8] = mk_oam(1, 0, 0, 0, 10'd300, t == 0 ? 10'd630 : 10'd1023, 8'h11);
      exp_cycles = model_line();
      run_line();
      d = first_diff(obs_w, exp_w);
      checks++;
      if (d != -1 || obs_w.size() != (t == 0 ? 10 : 0)) begin
        errors++;
        $display("FAIL clip%0d_writes: got %0d want %0d (diff %0d)", t, obs_w.size(), t == 0 ? 10 : 0, d);
      end
      checks++;
      if (!done_seen || obs_cycles != 22) begin
        errors++;
        $display("FAIL clip%0d_cycles: done=%0d cycles=%0d want 1 22", t, done_seen, obs_cycles);
      end
      end_line();
    end
  endtask

  task automatic test_overlap();
    int d;
    buf_entries = '0;
    set_entry(1, 1'b1, 8'd20);
    set_entry(0, 1'b1, 8'd21);
    oam_mem[20] = mk_oam(1, 0, 0, 0, 10'd40, 10'd300, 8'h21);
    oam_mem[21] = mk_oam(1, 0, 0, 1, 10'd40, 10'd300, 8'h22);
    spr_rom[12'h212] = {16{4'h3}};
    spr_rom[12'h222] = {16{4'h9}};
    sy = 10'd42;
    exp_cycles = model_line();
    run_line();
    d = first_diff(obs_w, exp_w);
    checks++;
    if (d != -1 || obs_cycles != exp_cycles) begin
      errors++;
      $display("FAIL overlap_order: diff=%0d cycles=%0d want -1 %0d", d, obs_cycles, exp_cycles);
    end
    for (int c = 0; c < 16; c++) begin
      checks++;
      if (linebuf[300 + c] !== 5'h19) begin
        errors++;
        $display("FAIL overlap_final x=%0d: got %h want 19", 300 + c, linebuf[300 + c]);
      end
    end
    end_line();
  endtask

  task automatic test_disabled();
    buf_entries = '0;
    exp_cycles = model_line();
    run_line();
    checks++;
    if (!done_seen || obs_cycles != MAX_OBJECT || obs_w.size() != 0) begin
      errors++;
      $display("FAIL disabled_all: cycles=%0d writes=%0d want %0d 0", obs_cycles, obs_w.size(), MAX_OBJECT);
    end
    end_line();
    set_entry(2, 1'b1, 8'd30);
    oam_mem[30] = mk_oam(0, 0, 0, 0, 10'd0, 10'd10, 8'h33);
    sy = 10'd4;
    exp_cycles = model_line();
    run_line();
    checks++;
    if (!done_seen || obs_cycles != exp_cycles || obs_w.size() != 0) begin
      errors++;
      $display("FAIL disabled_oam: cycles=%0d writes=%0d want %0d 0", obs_cycles, obs_w.size(), exp_cycles);
    end
    end_line();
  endtask

  task automatic test_random();
    int d;
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < MAX_OBJECT; i++) begin
        set_entry(i, ($urandom_range(3) != 0), 8'($urandom));
        oam_mem[buf_entries[i*9+1 +: 6]] =
          mk_oam(($urandom_range(3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 10'($urandom), ($urandom_range(3) == 0) ? 10'($urandom_range(1023, 600)) : 10'($urandom),
                 8'($urandom));
      end
      sy = 10'($urandom);
      exp_cycles = model_line();
      run_line();
      d = first_diff(obs_w, exp_w);
      checks++;
      if (!done_seen || obs_cycles != exp_cycles) begin
        errors++;
        $display("FAIL rand%0d_cycles: done=%0d got %0d want %0d", n, done_seen, obs_cycles, exp_cycles);
      end
      checks++;
      if (d != -1) begin
        errors++;
        $display("FAIL rand%0d_writes: got %0d want %0d (diff %0d)", n, obs_w.size(), exp_w.size(), d);
      end
      checks++;
      if (first_diff(obs_sa, exp_sa) != -1) begin
        errors++;
        $display("FAIL rand%0d_fetch: got %0d rows want %0d", n, obs_sa.size(), exp_sa.size());
      end
      end_line();
    end
  endtask

  task automatic test_abort();
    int cnt;
    buf_entries = '0;
    set_entry(0, 1'b1, 8'd3);
    oam_mem[3]       = mk_oam(1, 0, 0, 0, 10'd50, 10'd100, 8'd7);
    spr_rom[12'h073] = {16{4'h5}};
    sy = 10'd53;
    // Drop line_prepared while drawing column 5.
    cnt = 0;
    obs_w.delete();
    @(posedge clk); #1 line_prepared = 1'b1;
    for (int k = 0; k < 100 && cnt < 11; k++) begin
      @(negedge clk);
      if (busy) cnt++;
      if (lb_we) obs_w.push_back({lb_addr, lb_data});
    end
    @(posedge clk); #1 line_prepared = 1'b0;
    @(negedge clk);
    checks++;
    if (lb_we !== 1'b0 || obs_w.size() != 5) begin
      errors++;
      $display("FAIL abort_we: we=%b prior writes=%0d want 0 5", lb_we, obs_w.size());
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || line_done !== 1'b0 || lb_we !== 1'b0) begin
        errors++;
        $display("FAIL abort_idle%0d: busy=%b done=%b we=%b want 000", k, busy, line_done, lb_we);
      end
    end
    // Asynchronous reset in the middle of drawing.
    cnt = 0;
    @(posedge clk); #1 line_prepared = 1'b1;
    for (int k = 0; k < 100 && cnt < 9; k++) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    checks++;
    if (lb_we !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: we=%b want 1 while drawing", lb_we);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (lb_we !== 1'b0 || busy !== 1'b0 || lb_addr !== 10'h0 || lb_data !== 5'h0 || line_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: we=%b busy=%b addr=%h data=%h done=%b want all 0",
               lb_we, busy, lb_addr, lb_data, line_done);
    end
    line_prepared = 1'b0;
    @(negedge clk) reset_n = 1'b1;
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) spr_rom[a] = {$urandom, $urandom};
    for (int a = 0; a < 64; a++)   oam_mem[a] = '0;
    for (int a = 0; a < 1024; a++) linebuf[a] = '0;
    test_reset();
    test_single();
    test_flip();
    test_clip();
    test_overlap();
    test_disabled();
    test_random();
    test_abort();
    test_single();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
